// File: rtl/window_shift_buf_pkg.sv
// Shared definitions for the window shift buffer.
//   - default geometry constants (channels, max kernel edge, pixel width)
//   - FSM state encoding
//   - latched command record
//   - flat index helper for window element (channel t, slot c, row r)
package window_shift_buf_pkg;

  localparam int TN_DEF   = 4;
  localparam int KMAX_DEF = 5;
  localparam int FW_DEF   = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FULL = 2'd2
  } wsb_state_e;

  // Command captured on an accepted start.
  typedef struct packed {
    logic [3:0] k;     // kernel edge K
    logic [3:0] need;  // columns to accept before the window is full
    logic       src;   // column source select
  } wsb_cmd_t;

  // Element index of (t, c, r) inside the flat window bus.
  function automatic int win_idx(input int t, input int c, input int r, input int kmax);
    return t * kmax * kmax + c * kmax + r;
  endfunction

endpackage

// File: rtl/window_shift_buf_win_chan_shift.sv
// win_chan_shift: column shift storage for one channel.
//   clk        rising-edge clock
//   rst_n      async active-low reset, clears all slots
//   shift_en_i accept one column this cycle
//   k_i        active kernel edge; only slots 0..k_i-1 move
//   col_i      incoming column, row r at [r*FW +: FW]
//   win_o      KMAX slots x KMAX rows, element c*KMAX + r
module win_chan_shift
  import window_shift_buf_pkg::*;
#(
  parameter int KMAX = KMAX_DEF,
  parameter int FW   = FW_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   shift_en_i,
  input  logic [3:0]             k_i,
  input  logic [KMAX*FW-1:0]     col_i,
  output logic [KMAX*KMAX*FW-1:0] win_o
);

  logic [KMAX-1:0][KMAX*FW-1:0] slot_q;

  // New column lands in slot 0; slots below K move up by one, slot K-1
  // falls off, slots at or above K keep their contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else if (shift_en_i) begin
      slot_q[0] <= col_i;
      for (int c = 1; c < KMAX; c++) begin
        if (4'(c) < k_i) slot_q[c] <= slot_q[c-1];
      end
    end
  end

  for (genvar c = 0; c < KMAX; c++) begin : g_slot
    assign win_o[win_idx(0, c, 0, KMAX)*FW +: KMAX*FW] = slot_q[c];
  end

endmodule

// File: rtl/window_shift_buf.sv
// window_shift_buf: builds a KxK sliding window per channel from a stream
// of columns, either as a full reload or as an incremental stride shift.
//   clk, rst_n              clock, async active-low reset
//   start                   command pulse (kn_size, stride, fresh, src_sel)
//   col_data_0/1            column sources, channel t row r at (t*KMAX+r)*FW
//   col_valid / col_ready   column handshake (ready only while loading)
//   win_data                window, element t*KMAX*KMAX + c*KMAX + r
//   win_valid / win_ready   window handshake
//   busy, shift_done, cfg_err  status
// Build option: WSB_ZERO_PAD_EN masks rows/slots at or beyond K to zero on
// win_data; without it those elements show raw column bits / held slots.
module window_shift_buf
  import window_shift_buf_pkg::*;
#(
  parameter int TN   = TN_DEF,
  parameter int KMAX = KMAX_DEF,
  parameter int FW   = FW_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [3:0]                  kn_size,
  input  logic [3:0]                  stride,
  input  logic                        fresh,
  input  logic                        src_sel,
  input  logic [TN*KMAX*FW-1:0]       col_data_0,
  input  logic [TN*KMAX*FW-1:0]       col_data_1,
  input  logic                        col_valid,
  output logic                        col_ready,
  output logic [TN*KMAX*KMAX*FW-1:0]  win_data,
  output logic                        win_valid,
  input  logic                        win_ready,
  output logic                        busy,
  output logic                        shift_done,
  output logic                        cfg_err
);

  localparam int         CW    = TN * KMAX * FW;
  localparam int         WW    = TN * KMAX * KMAX * FW;
  localparam logic [3:0] KMAX4 = 4'(KMAX);

  wsb_state_e state_q;
  wsb_cmd_t   cmd_q;
  logic [4:0] cnt_q;
  logic       cfg_err_q;
  logic       shift_done_q;

  logic [3:0]    need_d;
  logic [4:0]    cnt_d;
  logic          k_bad;
  logic          col_fire;
  logic [CW-1:0] col_sel;
  logic [WW-1:0] win_raw;

  assign k_bad    = (kn_size == 4'd0) || (kn_size > KMAX4);
  // Incremental shifts never need more than K columns.
  assign need_d   = fresh ? kn_size : ((stride < kn_size) ? stride : kn_size);
  assign cnt_d    = cnt_q + 5'd1;
  assign col_ready = (state_q == S_LOAD);
  assign col_fire  = col_valid & col_ready;
  assign col_sel   = cmd_q.src ? col_data_1 : col_data_0;

  assign win_valid  = (state_q == S_FULL);
  assign busy       = (state_q != S_IDLE);
  assign shift_done = shift_done_q;
  assign cfg_err    = cfg_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      cnt_q        <= '0;
      cfg_err_q    <= 1'b0;
      shift_done_q <= 1'b0;
    end else begin
      cfg_err_q    <= 1'b0;
      shift_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (k_bad) begin
              cfg_err_q <= 1'b1;
            end else begin
              cmd_q.k    <= kn_size;
              cmd_q.need <= need_d;
              cmd_q.src  <= src_sel;
              cnt_q      <= '0;
              state_q    <= (need_d == 4'd0) ? S_FULL : S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (col_fire) begin
            if (cnt_d == {1'b0, cmd_q.need}) begin
              cnt_q   <= '0;
              state_q <= S_FULL;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        S_FULL: begin
          // start in this cycle is dropped: not yet back in IDLE.
          if (win_ready) begin
            state_q      <= S_IDLE;
            shift_done_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // One storage lane per channel; the instance array slices col_sel and
  // win_raw per channel, which matches the flat bus layouts.
  win_chan_shift #(
    .KMAX(KMAX),
    .FW  (FW)
  ) u_chan [TN-1:0] (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en_i(col_fire),
    .k_i       (cmd_q.k),
    .col_i     (col_sel),
    .win_o     (win_raw)
  );

`ifdef WSB_ZERO_PAD_EN
  always_comb begin
    win_data = win_raw;
    for (int t = 0; t < TN; t++) begin
      for (int c = 0; c < KMAX; c++) begin
        for (int r = 0; r < KMAX; r++) begin
          if ((4'(c) >= cmd_q.k) || (4'(r) >= cmd_q.k))
            win_data[win_idx(t, c, r, KMAX)*FW +: FW] = '0;
        end
      end
    end
  end
`else
  assign win_data = win_raw;
`endif

endmodule

// File: tb/tb_window_shift_buf.sv
// Scoreboard bench for window_shift_buf: stimulus pushes expected windows,
// a monitor pops and compares on every window handshake.
module tb_window_shift_buf;
  localparam int TN = 4, KMAX = 5, FW = 8;
  localparam int CW = TN * KMAX * FW;
  localparam int WW = TN * KMAX * KMAX * FW;

  logic          clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [3:0]    kn_size = '0, stride = '0;
  logic          fresh = 1'b0, src_sel = 1'b0;
  logic [CW-1:0] col_data_0 = '0, col_data_1 = '0;
  logic          col_valid = 1'b0, col_ready;
  logic [WW-1:0] win_data;
  logic          win_valid, win_ready = 1'b0;
  logic          busy, shift_done, cfg_err;

  window_shift_buf #(.TN(TN), .KMAX(KMAX), .FW(FW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kn_size(kn_size), .stride(stride),
    .fresh(fresh), .src_sel(src_sel), .col_data_0(col_data_0), .col_data_1(col_data_1),
    .col_valid(col_valid), .col_ready(col_ready), .win_data(win_data),
    .win_valid(win_valid), .win_ready(win_ready), .busy(busy),
    .shift_done(shift_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, beats = 0;
  logic [WW-1:0] exp_q[$];
  logic [KMAX*FW-1:0] mdl [TN][KMAX];
  int  mdl_k = 0;
  bit  cur_src = 1'b0;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] b(input logic v);
    return WW'(v);
  endfunction

  function automatic logic [WW-1:0] h(input logic [7:0] v);
    return WW'(v);
  endfunction

  function automatic logic [WW-1:0] pix(input int t, input int c, input int r);
    return WW'(win_data[(t*KMAX*KMAX + c*KMAX + r)*FW +: FW]);
  endfunction

  // Column c: pixel = 16*c + row + 5*channel.
  function automatic logic [CW-1:0] mkcol(input int c);
    logic [CW-1:0] v;
    v = '0;
    for (int t = 0; t < TN; t++)
      for (int r = 0; r < KMAX; r++)
        v[(t*KMAX+r)*FW +: FW] = 8'(16*c + r + 5*t);
    return v;
  endfunction

  function automatic logic [WW-1:0] build_exp();
    logic [WW-1:0] e;
    logic [FW-1:0] p;
    e = '0;
    for (int t = 0; t < TN; t++)
      for (int c = 0; c < KMAX; c++)
        for (int r = 0; r < KMAX; r++) begin
          p = mdl[t][c][r*FW +: FW];
`ifdef WSB_ZERO_PAD_EN
          if (r >= mdl_k || c >= mdl_k) p = '0;
`endif
          e[(t*KMAX*KMAX + c*KMAX + r)*FW +: FW] = p;
        end
    return e;
  endfunction

  task automatic mdl_clear();
    for (int t = 0; t < TN; t++)
      for (int c = 0; c < KMAX; c++) mdl[t][c] = '0;
    mdl_k = 0;
  endtask

  task automatic mdl_shift(input logic [CW-1:0] d);
    for (int t = 0; t < TN; t++) begin
      for (int c = KMAX-1; c >= 1; c--)
        if (c < mdl_k) mdl[t][c] = mdl[t][c-1];
      mdl[t][0] = d[t*KMAX*FW +: KMAX*FW];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int k, input int s, input bit f, input bit src);
    kn_size = 4'(k); stride = 4'(s); fresh = f; src_sel = src;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (k >= 1 && k <= KMAX) begin
      mdl_k = k;
      cur_src = src;
    end
  endtask

  task automatic send_col(input int c, input bit gap);
    logic [CW-1:0] d;
    int n;
    d = mkcol(c);
    if (gap) begin
      col_valid = 1'b0;
      tick();
    end
    if (cur_src) begin col_data_1 = d; col_data_0 = ~d; end
    else         begin col_data_0 = d; col_data_1 = ~d; end
    col_valid = 1'b1;
    n = 0;
    while (!col_ready && n < 50) begin tick(); n++; end
    chk("col_ready_wait", b(col_ready), b(1'b1));
    tick();
    col_valid = 1'b0;
    mdl_shift(d);
  endtask

  task automatic wait_win(input int hold, input bit sw);
    int n;
    n = 0;
    while (!win_valid && n < 50) begin tick(); n++; end
    chk("win_valid_wait", b(win_valid), b(1'b1));
    repeat (hold) tick();
    if (hold > 0 && exp_q.size() > 0) chk("hold_data", win_data, exp_q[0]);
    win_ready = 1'b1;
    if (sw) begin start = 1'b1; kn_size = 4'd5; fresh = 1'b1; stride = 4'd0; end
    tick();
    win_ready = 1'b0;
    start = 1'b0;
    chk("shift_done_pulse", b(shift_done), b(1'b1));
    chk("idle_after_win", b(busy), b(1'b0));
    tick();
    chk("shift_done_end", b(shift_done), b(1'b0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_win_data"}, win_data, '0);
    chk({tag, "_win_valid"}, b(win_valid), b(1'b0));
    chk({tag, "_col_ready"}, b(col_ready), b(1'b0));
    chk({tag, "_busy"}, b(busy), b(1'b0));
    chk({tag, "_shift_done"}, b(shift_done), b(1'b0));
    chk({tag, "_cfg_err"}, b(cfg_err), b(1'b0));
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (win_valid && win_ready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL win_unexpected act=%0h exp=none", win_data);
      end else begin
        chk("win_data", win_data, exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) if (col_valid && col_ready) beats++;

  initial begin
    int b0;
    int n;
    mdl_clear();
    #2 rst_n = 1'b0;
    repeat (2) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // Full reload, K=5, source 0.
    do_start(5, 0, 1'b1, 1'b0);
    chk("t1_busy", b(busy), b(1'b1));
    chk("t1_col_ready", b(col_ready), b(1'b1));
    for (int c = 0; c < 5; c++) send_col(c, 1'b0);
    exp_q.push_back(build_exp());
    chk("t1_latency", b(win_valid), b(1'b1));
    chk("t1_s0r0", pix(0, 0, 0), h(8'h40));
    chk("t1_s4r0", pix(0, 4, 0), h(8'h00));
    chk("t1_s0r3", pix(0, 0, 3), h(8'h43));
    chk("t1_ch1_s0r0", pix(1, 0, 0), h(8'h45));
    wait_win(0, 1'b0);

    // Incremental stride 2; a start while loading must be ignored.
    b0 = beats;
    do_start(5, 2, 1'b0, 1'b0);
    send_col(5, 1'b0);
    kn_size = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t2_start_in_load_err", b(cfg_err), b(1'b0));
    chk("t2_still_load", b(col_ready), b(1'b1));
    send_col(6, 1'b0);
    exp_q.push_back(build_exp());
    chk("t2_beats", WW'(beats - b0), WW'(2));
    chk("t2_s0r0", pix(0, 0, 0), h(8'h60));
    chk("t2_s1r0", pix(0, 1, 0), h(8'h50));
    chk("t2_s2r0", pix(0, 2, 0), h(8'h40));
    wait_win(0, 1'b0);

    // K=3 reload from source 1.
    do_start(3, 0, 1'b1, 1'b1);
    for (int c = 7; c < 10; c++) send_col(c, 1'b0);
    exp_q.push_back(build_exp());
    chk("t3_s0r0", pix(0, 0, 0), h(8'h90));
    chk("t3_s2r0", pix(0, 2, 0), h(8'h70));
    chk("t3_s1r2", pix(0, 1, 2), h(8'h82));
`ifdef WSB_ZERO_PAD_EN
    chk("t3_s3r0_pad", pix(0, 3, 0), h(8'h00));
    chk("t3_s0r4_pad", pix(0, 0, 4), h(8'h00));
`else
    chk("t3_s3r0_held", pix(0, 3, 0), h(8'h30));
    chk("t3_s0r4_raw", pix(0, 0, 4), h(8'h94));
`endif
    wait_win(0, 1'b0);

    // Illegal kernel sizes.
    for (int i = 0; i < 2; i++) begin
      do_start(i * 6, 0, 1'b1, 1'b0);
      chk("cfg_err_pulse", b(cfg_err), b(1'b1));
      chk("cfg_err_busy", b(busy), b(1'b0));
      tick();
      chk("cfg_err_clear", b(cfg_err), b(1'b0));
    end

    // stride 0: full without columns; start coincident with win handshake.
    b0 = beats;
    do_start(5, 0, 1'b0, 1'b0);
    chk("t4_stride0_full", b(win_valid), b(1'b1));
    exp_q.push_back(build_exp());
    wait_win(2, 1'b1);
    chk("t4_no_beats", WW'(beats - b0), WW'(0));

    // Stalled column stream and stalled window consumer.
    do_start(5, 0, 1'b1, 1'b0);
    for (int c = 10; c < 15; c++) send_col(c, 1'b1);
    exp_q.push_back(build_exp());
    wait_win(10, 1'b0);

    // Reset in the middle of a load.
    do_start(5, 0, 1'b1, 1'b0);
    send_col(1, 1'b0);
    send_col(2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    mdl_clear();
    tick();
    rst_n = 1'b1;
    tick();
    do_start(4, 0, 1'b1, 1'b0);
    for (int c = 1; c < 5; c++) send_col(c, 1'b0);
    exp_q.push_back(build_exp());
    chk("t6_s0r0", pix(0, 0, 0), h(8'h40));
    chk("t6_s3r0", pix(0, 3, 0), h(8'h10));
    chk("t6_s4r0", pix(0, 4, 0), h(8'h00));
    wait_win(0, 1'b0);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin tick(); n++; end
    chk("sb_empty", WW'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
